// File: rtl/joy_db_select.sv
// joy_db_select: conditioning stage behind the DB9-MD and DB15 joystick readers.
// This block:
//   - synchronises both readers' player words into clk_sys;
//   - works out which adapter is fitted;
//   - debounces the selected words and latches per-player presence;
//   - drives joy1/joy2, joy_raw and the OSD combo button.
module joy_db_select #(
    parameter logic [15:0] DB_CYCLES    = 16'd4096,
    parameter logic [3:0]  DET_CYCLES   = 4'd8,
    parameter logic [23:0] COMBO_CYCLES = 24'd2500000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        md_detect_n,
    input  logic        db15_conflict_n,
    input  logic [15:0] joy_md1,
    input  logic [15:0] joy_md2,
    input  logic [15:0] joy_15_1,
    input  logic [15:0] joy_15_2,
    output logic [15:0] joy1,
    output logic [15:0] joy2,
    output logic [5:0]  joy_raw,
    output logic [1:0]  mode,
    output logic        p1_en,
    output logic        p2_en,
    output logic        osd_btn
);

    typedef enum logic [1:0] {
        ST_DB15 = 2'd0,
        ST_NONE = 2'd1,
        ST_MD   = 2'd2
    } det_state_t;

    det_state_t state_q;
    det_state_t state_d;

    logic [1:0]        md_sync;
    logic [1:0]        cf_sync;
    logic [3:0][15:0]  word_meta;
    logic [3:0][15:0]  word_sync;
    logic              md_s;
    logic              cf_s;

    logic [3:0]        md_cnt;
    logic [3:0]        cf_cnt;
    logic              md_ok;
    logic              cf_ok;
    logic              mode_chg;

    logic [1:0][15:0]  src;
    logic [1:0][15:0]  prev_q;
    logic [1:0][15:0]  db_q;
    logic [1:0][15:0]  db_cnt;

    logic              p1_set;
    logic              p2_set;
    logic              p1_en_d;
    logic              p2_en_d;
    logic              show;

    logic              combo;
    logic [23:0]       combo_cnt;

    assign md_s = md_sync[1];
    assign cf_s = cf_sync[1];

    // Two-flop synchronisers; word bits are independent, tearing is removed by the debouncer.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        // NOTE: no memories in this block; every register has a reset value.
        if (RESET) begin
            md_sync   <= 2'b11;
            cf_sync   <= 2'b11;
            word_meta <= '0;
            word_sync <= '0;
        end else begin
            md_sync   <= {md_sync[0], md_detect_n};
            cf_sync   <= {cf_sync[0], db15_conflict_n};
            word_meta <= {joy_15_2, joy_15_1, joy_md2, joy_md1};
            word_sync <= word_meta;
        end
    end

    // Detect qualifiers: count consecutive low samples, clear on high, saturate at DET_CYCLES.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            md_cnt <= '0;
            cf_cnt <= '0;
        end else begin
            if (md_s)
                md_cnt <= '0;
            else if (md_cnt != DET_CYCLES)
                md_cnt <= md_cnt + 4'd1;

            if (cf_s)
                cf_cnt <= '0;
            else if (cf_cnt != DET_CYCLES)
                cf_cnt <= cf_cnt + 4'd1;
        end
    end

    assign md_ok = (md_cnt == DET_CYCLES);
    assign cf_ok = (cf_cnt == DET_CYCLES);

    // Detect FSM state register; the state is sticky until RESET.
    always_ff @(posedge clk_sys) begin
        if (RESET)
            state_q <= ST_DB15;
        else
            state_q <= state_d;
    end

    // Detect FSM next state; MD takes priority over the DB15 conflict.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_DB15: begin
                if (md_ok)
                    state_d = ST_MD;
                else if (cf_ok)
                    state_d = ST_NONE;
            end
            ST_NONE: begin
                if (md_ok)
                    state_d = ST_MD;
            end
            ST_MD:   state_d = ST_MD;
            default: state_d = ST_DB15;
        endcase
    end

    assign mode_chg = (state_d != state_q);
    assign mode     = state_q;

    // Source mux: the fitted adapter's words, or zero when DB15 is blocked.
    always_comb begin
        src = '0;
        unique case (state_q)
            ST_MD:   src = {word_sync[1], word_sync[0]};
            ST_DB15: src = {word_sync[3], word_sync[2]};
            default: src = '0;
        endcase
    end

    // Per-player debounce. The word loads on the same edge the counter reaches DB_CYCLES-1.
    // It keeps reloading while the counter is saturated, and the samples are still equal then.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            prev_q <= '0;
            db_q   <= '0;
            db_cnt <= '0;
        end else if (mode_chg) begin
            prev_q <= src;
            db_q   <= '0;
            db_cnt <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                prev_q[p] <= src[p];
                if (src[p] != prev_q[p]) begin
                    db_cnt[p] <= '0;
                end else begin
                    if (db_cnt[p] != DB_CYCLES - 16'd1)
                        db_cnt[p] <= db_cnt[p] + 16'd1;
                    if (db_cnt[p] >= DB_CYCLES - 16'd2)
                        db_q[p] <= src[p];
                end
            end
        end
    end

    // A splitter-less MD pad shows up on both words.
    // In MD, player 2 only counts as present while player 1's bit2 is clear.
    assign p1_set  = db_q[0][2];
    assign p2_set  = db_q[1][2] & ~((state_q == ST_MD) & db_q[0][2]);
    assign p1_en_d = p1_en | p1_set;
    assign p2_en_d = p2_en | p2_set;
    assign show    = p1_en_d | p2_en_d;

    // Sticky presence flags and gated output words.
    // The gate uses next-cycle presence, so the first accepted word is not lost.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            p1_en   <= 1'b0;
            p2_en   <= 1'b0;
            joy1    <= '0;
            joy2    <= '0;
            joy_raw <= '0;
        end else begin
            p1_en   <= p1_en_d;
            p2_en   <= p2_en_d;
            joy1    <= show ? db_q[0] : 16'h0000;
            joy2    <= show ? db_q[1] : 16'h0000;
            joy_raw <= joy1[5:0] | joy2[5:0];
        end
    end

    assign combo = joy1[10] & joy1[6];

    // OSD combo hold timer: counts while Start+B is held and saturates at COMBO_CYCLES.
    always_ff @(posedge clk_sys) begin
        if (RESET)
            combo_cnt <= '0;
        else if (!combo)
            combo_cnt <= '0;
        else if (combo_cnt != COMBO_CYCLES)
            combo_cnt <= combo_cnt + 24'd1;
    end

    assign osd_btn = (combo_cnt == COMBO_CYCLES);

endmodule

// File: tb/tb_joy_db_select.sv
// Directed bench for joy_db_select.
// Expected values are queued when stimulus is applied and compared once the DUT should show them.
module tb_joy_db_select;

    localparam int DB    = 16;
    localparam int DET   = 8;
    localparam int COMBO = 40;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic        md_detect_n     = 1'b1;
    logic        db15_conflict_n = 1'b1;
    logic [15:0] joy_md1  = '0;
    logic [15:0] joy_md2  = '0;
    logic [15:0] joy_15_1 = '0;
    logic [15:0] joy_15_2 = '0;
    logic [15:0] joy1;
    logic [15:0] joy2;
    logic [5:0]  joy_raw;
    logic [1:0]  mode;
    logic        p1_en;
    logic        p2_en;
    logic        osd_btn;

    int n_assert = 0;
    int n_fail   = 0;

    typedef enum {SIG_JOY1, SIG_JOY2, SIG_RAW, SIG_MODE, SIG_P1, SIG_P2, SIG_OSD} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    joy_db_select #(
        .DB_CYCLES    (16'(DB)),
        .DET_CYCLES   (4'(DET)),
        .COMBO_CYCLES (24'(COMBO))
    ) dut (
        .clk_sys         (clk_sys),
        .RESET           (RESET),
        .md_detect_n     (md_detect_n),
        .db15_conflict_n (db15_conflict_n),
        .joy_md1         (joy_md1),
        .joy_md2         (joy_md2),
        .joy_15_1        (joy_15_1),
        .joy_15_2        (joy_15_2),
        .joy1            (joy1),
        .joy2            (joy2),
        .joy_raw         (joy_raw),
        .mode            (mode),
        .p1_en           (p1_en),
        .p2_en           (p2_en),
        .osd_btn         (osd_btn)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] observe(sig_e s);
        case (s)
            SIG_JOY1: return joy1;
            SIG_JOY2: return joy2;
            SIG_RAW:  return {10'd0, joy_raw};
            SIG_MODE: return {14'd0, mode};
            SIG_P1:   return {15'd0, p1_en};
            SIG_P2:   return {15'd0, p2_en};
            SIG_OSD:  return {15'd0, osd_btn};
            default:  return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        // Reset state.
        tick(3);
        push("rst_joy1", SIG_JOY1, 16'h0000);
        push("rst_joy2", SIG_JOY2, 16'h0000);
        push("rst_raw",  SIG_RAW,  16'h0000);
        push("rst_mode", SIG_MODE, 16'd0);
        push("rst_p1",   SIG_P1,   16'd0);
        push("rst_p2",   SIG_P2,   16'd0);
        push("rst_osd",  SIG_OSD,  16'd0);
        check_sb();

        // 1: DB15 word with bit2 arrives after 2 + DB + 1 cycles and enables p1.
        RESET    = 1'b0;
        joy_15_1 = 16'h0004;
        tick(DB + 2);
        push("t1_joy1_early", SIG_JOY1, 16'h0000);
        push("t1_p1_early",   SIG_P1,   16'd0);
        check_sb();
        tick(1);
        push("t1_joy1", SIG_JOY1, 16'h0004);
        push("t1_p1",   SIG_P1,   16'd1);
        push("t1_raw_lag", SIG_RAW, 16'h0000);
        push("t1_mode", SIG_MODE, 16'd0);
        push("t1_p2",   SIG_P2,   16'd0);
        check_sb();
        tick(1);
        push("t1_raw", SIG_RAW, 16'h0004);
        check_sb();

        // 4: bit0 toggling every DB/2 cycles never gets through.
        for (int i = 0; i < 6; i++) begin
            joy_15_1 = (i % 2 == 0) ? 16'h0005 : 16'h0004;
            tick(DB / 2);
            push("t4_bounce_joy1", SIG_JOY1, 16'h0004);
            check_sb();
        end
        joy_15_1 = 16'h0005;
        tick(DB + 2);
        push("t4_hold_early", SIG_JOY1, 16'h0004);
        check_sb();
        tick(1);
        push("t4_hold_joy1", SIG_JOY1, 16'h0005);
        check_sb();

        // 5a: Start+B held for COMBO cycles raises osd_btn.
        joy_15_1 = 16'h0440;
        tick(DB + 3);
        push("t5_joy1", SIG_JOY1, 16'h0440);
        push("t5_osd_start", SIG_OSD, 16'd0);
        check_sb();
        tick(COMBO - 1);
        push("t5_osd_early", SIG_OSD, 16'd0);
        check_sb();
        tick(1);
        push("t5_osd_on", SIG_OSD, 16'd1);
        check_sb();

        // 5b: release; osd_btn drops one cycle after joy1 loses the combo.
        joy_15_1 = 16'h0000;
        tick(DB + 3);
        push("t5_rel_joy1", SIG_JOY1, 16'h0000);
        push("t5_rel_osd_hold", SIG_OSD, 16'd1);
        check_sb();
        tick(1);
        push("t5_rel_osd_off", SIG_OSD, 16'd0);
        check_sb();

        // 5c: combo held for COMBO-1 cycles never raises osd_btn.
        joy_15_1 = 16'h0440;
        for (int k = 0; k < COMBO - 1 + DB + 6; k++) begin
            tick(1);
            if (k == COMBO - 2)
                joy_15_1 = 16'h0000;
            if (k == DB + 2)
                push("t5_short_joy1", SIG_JOY1, 16'h0440);
            push("t5_short_osd", SIG_OSD, 16'd0);
            check_sb();
        end

        // 2: 7-cycle MD detect pulse is ignored; 8 cycles switch to MD and clear debounced words.
        joy_15_1 = 16'h0003;
        joy_md1  = 16'h0020;
        joy_md2  = 16'h0000;
        tick(DB + 4);
        push("t2_pre_joy1", SIG_JOY1, 16'h0003);
        check_sb();
        md_detect_n = 1'b0;
        tick(7);
        md_detect_n = 1'b1;
        tick(10);
        push("t2_short_mode", SIG_MODE, 16'd0);
        check_sb();
        md_detect_n = 1'b0;
        tick(8);
        md_detect_n = 1'b1;
        tick(2);
        push("t2_mode_early", SIG_MODE, 16'd0);
        check_sb();
        tick(1);
        push("t2_mode_md", SIG_MODE, 16'd2);
        check_sb();
        tick(1);
        push("t2_cleared_joy1", SIG_JOY1, 16'h0000);
        push("t2_p1_sticky", SIG_P1, 16'd1);
        check_sb();
        tick(DB + 5);
        push("t2_md_joy1", SIG_JOY1, 16'h0020);
        push("t2_mode_stays", SIG_MODE, 16'd2);
        check_sb();

        // 3: mirrored MD pad does not enable p2; p1 released with p2 held does.
        joy_md1 = 16'h0004;
        joy_md2 = 16'h0004;
        tick(DB + 4);
        push("t3_mirror_joy1", SIG_JOY1, 16'h0004);
        push("t3_mirror_joy2", SIG_JOY2, 16'h0004);
        push("t3_mirror_p1",   SIG_P1,   16'd1);
        push("t3_mirror_p2",   SIG_P2,   16'd0);
        check_sb();
        joy_md1 = 16'h0000;
        tick(DB + 2);
        push("t3_p2_early", SIG_P2, 16'd0);
        check_sb();
        tick(1);
        push("t3_p2_set", SIG_P2, 16'd1);
        push("t3_joy1",   SIG_JOY1, 16'h0000);
        push("t3_joy2",   SIG_JOY2, 16'h0004);
        check_sb();
        tick(1);
        push("t3_raw", SIG_RAW, 16'h0004);
        check_sb();

        // 6: RESET for one cycle while in MD with p1_en and osd_btn set.
        joy_md1 = 16'h0440;
        tick(DB + 3 + COMBO);
        push("t6_pre_osd",  SIG_OSD,  16'd1);
        push("t6_pre_mode", SIG_MODE, 16'd2);
        push("t6_pre_p1",   SIG_P1,   16'd1);
        check_sb();
        RESET = 1'b1;
        tick(1);
        RESET   = 1'b0;
        joy_md1 = 16'h0000;
        joy_md2 = 16'h0000;
        push("t6_joy1", SIG_JOY1, 16'h0000);
        push("t6_joy2", SIG_JOY2, 16'h0000);
        push("t6_raw",  SIG_RAW,  16'h0000);
        push("t6_mode", SIG_MODE, 16'd0);
        push("t6_p1",   SIG_P1,   16'd0);
        push("t6_p2",   SIG_P2,   16'd0);
        push("t6_osd",  SIG_OSD,  16'd0);
        check_sb();

        // MD and conflict qualifying on the same cycle: MD wins.
        md_detect_n     = 1'b0;
        db15_conflict_n = 1'b0;
        tick(8);
        md_detect_n     = 1'b1;
        db15_conflict_n = 1'b1;
        tick(2);
        push("tie_mode_early", SIG_MODE, 16'd0);
        check_sb();
        tick(1);
        push("tie_mode_md", SIG_MODE, 16'd2);
        check_sb();

        // Conflict alone blocks DB15; the NONE source is zero, so a pad never enables p1.
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        push("rst2_mode", SIG_MODE, 16'd0);
        check_sb();
        db15_conflict_n = 1'b0;
        tick(8);
        db15_conflict_n = 1'b1;
        tick(3);
        push("none_mode", SIG_MODE, 16'd1);
        check_sb();
        joy_15_1 = 16'h0004;
        tick(DB + 5);
        push("none_joy1", SIG_JOY1, 16'h0000);
        push("none_p1",   SIG_P1,   16'd0);
        check_sb();
        md_detect_n = 1'b0;
        tick(8);
        md_detect_n = 1'b1;
        tick(3);
        push("none_to_md", SIG_MODE, 16'd2);
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
